instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Instruction encoder/sequencer: the inverse of the ID-stage op decoder.
- Accepts abstract commands (kind, registers, funct fields, 32-bit immediate) and emits legal 32-bit RV32I instruction words over a valid/ready stream.
- Expands pseudo-ops LI and CALL into two-word sequences.
- Feeds the debug/boot instruction injector in front of instruction memory and generates golden streams for the core's self-test.

Parameters:
- NOP_WORD, 32'h00000013, word emitted for kind NOP (ADDI x0,x0,0)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_kind  in  4  R=0, I_ARITH=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, FENCE=9, SYSTEM=10, NOP=11, LI=12, CALL=13; 14-15 illegal
- i_rd  in  5  destination register
- i_rs1  in  5  source register 1
- i_rs2  in  5  source register 2
- i_funct_3  in  3  funct3
- i_funct_7_5  in  1  funct7 bit 5 (R-type; SRAI for I_ARITH with funct3=101)
- i_imm  in  32  immediate / byte offset
- o_instr_valid  out  1  instruction word valid
- i_instr_ready  in  1  downstream accepts word
- o_instr  out  32  encoded instruction
- o_instr_last  out  1  final word of current command
- o_cmd_err  out  1  one-cycle pulse: illegal kind accepted

Behaviour:
- Reset (i_rst=1 at a clock edge), from any state including mid-expansion:
  - state=IDLE; o_instr_valid=0, o_instr=0, o_instr_last=0, o_cmd_err=0.
  - Pending second word is discarded.
  - o_cmd_ready is combinational and reads 1 from the first cycle after reset.
- Opcode bits [6:2] use the decoder's 5-bit op map; bits [1:0] are always 2'b11.
- Opcode values: R=01100, LOAD=00000, I_ARITH=00100, JALR=11001, JAL=11011, LUI=01101, AUIPC=00101, STORE=01000, BRANCH=11000, SYSTEM=11100, FENCE=00011.
- Immediate packing:
  - I: imm[11:0].
  - S: imm[11:5] | imm[4:0].
  - B: imm[12|10:5|4:1|11]; imm[0] ignored.
  - U: imm[31:12].
  - J: imm[20|10:1|11|19:12]; imm[0] ignored.
  - SYSTEM: imm[11:0] in the I field; rd/rs1 taken from ports.
- Shift immediates: for I_ARITH with funct3 of 001 or 101, bits [31:25] = {1'b0, i_funct_7_5, 5'b0} and shamt = imm[4:0].
- o_cmd_ready = !o_instr_valid | (i_instr_ready & o_instr_last & state==IDLE). This allows back-to-back single-word commands at 1 word/cycle.
- Latency: word 1 is registered and visible in the cycle after command acceptance.
- Output stability: o_instr, o_instr_valid and o_instr_last hold unchanged while o_instr_valid & !i_instr_ready.
- FSM states: IDLE, HOLD2.
  - IDLE, single-word kind accepted: load word, last=1, stay in IDLE.
  - IDLE, LI/CALL accepted needing two words: load word 1 with last=0 and latch word 2 internally; go to HOLD2.
  - HOLD2, word 1 handshake: load word 2 with last=1; go to IDLE.
- LI rd, imm:
  - If imm is a sign-extended 12-bit value: single ADDI rd,x0,imm[11:0].
  - Else hi = imm[31:12] + imm[11] (20-bit, wraps modulo 2^20) and lo = imm[11:0]. Emit LUI rd,hi, then ADDI rd,rd,lo only if lo != 0; if lo == 0, LUI is last.
- CALL rd, imm: AUIPC rd,hi; JALR rd,rd,lo. Same hi/lo split; always two words.
- Illegal kind (14, 15): command accepted, nothing emitted, o_cmd_err=1 for exactly one cycle.
- Field masking: rd is forced to 0 for STORE/BRANCH. rs2 is used only for R/STORE/BRANCH.

Optional Feature:
- Macro: OSIRIS_PSEUDO_EXPAND_EN.
- Defined: LI and CALL expand as above; HOLD2 state and the word-2 register exist.
- Undefined:
  - LI and CALL are treated as illegal kinds (accepted, o_cmd_err pulse, no word emitted).
  - HOLD2 and the word-2 register are removed; o_instr_last is tied to 1.

Decomposition:
- Package instr_enc_pkg holds:
  - cmd_kind_t enum;
  - 5-bit opcode localparams identical to the decoder's op map;
  - NOP constant;
  - function split_hi_lo returning {hi[19:0], lo[11:0]}.
- One sub-module, imm_packer: combinational; (kind, imm) -> 32-bit word with immediate bits placed and all other fields zero. The top-level block ORs in opcode, register and funct fields.

Test Plan:
- I_ARITH rd=1, rs1=0, f3=000, imm=5 -> one word 0x00500093, last=1, one cycle after accept.
- LI rd=5, imm=0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1).
- LI rd=1, imm=0x00000800 -> 0x000010B7, then 0x80008093. LI rd=1, imm=0xFFFFF800 -> single 0x80000093.
- Backpressure: hold i_instr_ready=0 for 3 cycles during LI -> word 1 stable, o_cmd_ready=0, no word 2 until word 1 is accepted. Then 3 back-to-back NOPs with ready=1 -> 3 words 0x00000013 in 3 consecutive cycles.
- Reset asserted in HOLD2 -> o_instr_valid=0 next cycle; following command produces a fresh word with no stale word 2.
- Kind=15 -> o_cmd_err pulses 1 cycle, o_instr_valid stays 0. With the macro undefined, kind LI gives the same response.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package instr_enc_pkg;

    // Abstract command kinds; 14 and 15 are illegal.
    typedef enum logic [3:0] {
        KIND_R       = 4'd0,
        KIND_I_ARITH = 4'd1,
        KIND_LOAD    = 4'd2,
        KIND_STORE   = 4'd3,
        KIND_BRANCH  = 4'd4,
        KIND_JAL     = 4'd5,
        KIND_JALR    = 4'd6,
        KIND_LUI     = 4'd7,
        KIND_AUIPC   = 4'd8,
        KIND_FENCE   = 4'd9,
        KIND_SYSTEM  = 4'd10,
        KIND_NOP     = 4'd11,
        KIND_LI      = 4'd12,
        KIND_CALL    = 4'd13
    } cmd_kind_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_HOLD2 = 1'b1
    } enc_state_t;

    // Opcode bits [6:2], identical to the ID-stage decoder's op map.
    localparam logic [4:0] OP_R       = 5'b01100;
    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_I_ARITH = 5'b00100;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;
    localparam logic [4:0] OP_FENCE   = 5'b00011;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Split a 32-bit constant into {hi[19:0], lo[11:0]} so that
    // (hi << 12) + sign_extend(lo) reproduces it; hi wraps modulo 2^20.
    function automatic logic [31:0] split_hi_lo(input logic [31:0] imm);
        logic [19:0] hi;
        hi = imm[31:12] + {19'd0, imm[11]};
        return {hi, imm[11:0]};
    endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Places immediate bits of a command into their RV32I positions; all other fields zero.
// Latency: combinational.
// Backpressure: none (pure function of kind and immediate).
module imm_packer
    import instr_enc_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word
);

    // Select the immediate format implied by the command kind.
    always_comb begin
        o_word = 32'd0;
        case (i_kind)
            KIND_I_ARITH, KIND_LOAD, KIND_JALR, KIND_FENCE, KIND_SYSTEM:
                o_word = {i_imm[11:0], 20'd0};
            KIND_STORE:
                o_word = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
            KIND_BRANCH:
                o_word = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
            KIND_LUI, KIND_AUIPC:
                o_word = {i_imm[31:12], 12'd0};
            KIND_JAL:
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
            default:
                o_word = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes abstract commands into RV32I words; LI/CALL may expand to two words.
// Latency: word 1 registered, visible the cycle after accept; word 2 after word 1's handshake.
// Backpressure: words hold while i_instr_ready is low; o_cmd_ready drops until the last word drains.
// Build option: OSIRIS_PSEUDO_EXPAND_EN enables LI/CALL expansion (otherwise they are illegal).
module instr_encoder
    import instr_enc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [3:0]  i_cmd_kind,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct_3,
    input  logic        i_funct_7_5,
    input  logic [31:0] i_imm,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic        o_instr_last,
    output logic        o_cmd_err
);

    logic [3:0]  pk_kind;
    logic [31:0] pk_imm;
    logic [31:0] pk_word;
    logic [6:0]  f7_f;
    logic [4:0]  rd_f, rs1_f, rs2_f, op_f;
    logic [2:0]  f3_f;
    logic        is_nop, legal;
    logic [31:0] word1;

    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        advance, accept, cmd_ready;

`ifdef OSIRIS_PSEUDO_EXPAND_EN
    logic        last_q, last_d;
    logic [31:0] word2_q, word2_d, word2;
    logic        two_words;
    logic [31:0] hilo;
    logic        imm_s12;
    enc_state_t  state_q, state_d;

    assign hilo    = split_hi_lo(i_imm);
    assign imm_s12 = (i_imm == {{20{i_imm[11]}}, i_imm[11:0]});
`endif

    imm_packer u_imm_packer (
        .i_kind (pk_kind),
        .i_imm  (pk_imm),
        .o_word (pk_word)
    );

    assign advance = vld_q & i_instr_ready;
    assign accept  = i_cmd_valid & cmd_ready;

    // Choose opcode, register/funct fields and packer input for the first word.
    always_comb begin
        pk_kind = i_cmd_kind;
        pk_imm  = i_imm;
        op_f    = OP_I_ARITH;
        f7_f    = 7'd0;
        rd_f    = i_rd;
        rs1_f   = i_rs1;
        rs2_f   = 5'd0;
        f3_f    = i_funct_3;
        is_nop  = 1'b0;
        legal   = 1'b1;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
        two_words = 1'b0;
        word2     = 32'd0;
`endif
        case (i_cmd_kind)
            KIND_R: begin
                op_f  = OP_R;
                rs2_f = i_rs2;
                f7_f  = {1'b0, i_funct_7_5, 5'd0};
            end
            KIND_I_ARITH: begin
                op_f = OP_I_ARITH;
                // Shifts carry funct7 in imm[11:5] and a 5-bit shamt.
                if (i_funct_3 == 3'b001 || i_funct_3 == 3'b101)
                    pk_imm = {20'd0, 1'b0, i_funct_7_5, 5'd0, i_imm[4:0]};
            end
            KIND_LOAD:   op_f = OP_LOAD;
            KIND_STORE: begin
                op_f  = OP_STORE;
                rd_f  = 5'd0;
                rs2_f = i_rs2;
            end
            KIND_BRANCH: begin
                op_f  = OP_BRANCH;
                rd_f  = 5'd0;
                rs2_f = i_rs2;
            end
            KIND_JAL: begin
                op_f  = OP_JAL;
                rs1_f = 5'd0;
                f3_f  = 3'd0;
            end
            KIND_JALR: begin
                op_f = OP_JALR;
                f3_f = 3'd0;
            end
            KIND_LUI: begin
                op_f  = OP_LUI;
                rs1_f = 5'd0;
                f3_f  = 3'd0;
            end
            KIND_AUIPC: begin
                op_f  = OP_AUIPC;
                rs1_f = 5'd0;
                f3_f  = 3'd0;
            end
            KIND_FENCE:  op_f = OP_FENCE;
            KIND_SYSTEM: op_f = OP_SYSTEM;
            KIND_NOP:    is_nop = 1'b1;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
            KIND_LI: begin
                f3_f  = 3'd0;
                rs1_f = 5'd0;
                if (imm_s12) begin
                    pk_kind = KIND_I_ARITH;
                    op_f    = OP_I_ARITH;
                end else begin
                    pk_kind   = KIND_LUI;
                    pk_imm    = {hilo[31:12], 12'd0};
                    op_f      = OP_LUI;
                    two_words = (hilo[11:0] != 12'd0);
                    word2     = {hilo[11:0], i_rd, 3'b000, i_rd, OP_I_ARITH, 2'b11};
                end
            end
            KIND_CALL: begin
                f3_f      = 3'd0;
                rs1_f     = 5'd0;
                pk_kind   = KIND_AUIPC;
                pk_imm    = {hilo[31:12], 12'd0};
                op_f      = OP_AUIPC;
                two_words = 1'b1;
                word2     = {hilo[11:0], i_rd, 3'b000, i_rd, OP_JALR, 2'b11};
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    assign word1 = is_nop ? NOP_WORD
                          : (pk_word | {f7_f, rs2_f, rs1_f, f3_f, rd_f, op_f, 2'b11});

`ifdef OSIRIS_PSEUDO_EXPAND_EN
    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: enter HOLD2 on a two-word accept, leave when word 1 is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && legal && two_words) state_d = ST_HOLD2;
            ST_HOLD2: if (advance) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: new commands only when the last word is draining in IDLE.
    always_comb begin
        cmd_ready = ~vld_q | (i_instr_ready & last_q & (state_q == ST_IDLE));
    end

    assign o_instr_last = last_q;
`else
    // Output decode: every word is last, so accept whenever the output slot frees.
    always_comb begin
        cmd_ready = ~vld_q | i_instr_ready;
    end

    assign o_instr_last = 1'b1;
`endif

    // Output slot update: drain on handshake, refill from a command or the held word 2.
    always_comb begin
        vld_d   = vld_q & ~advance;
        instr_d = instr_q;
        err_d   = 1'b0;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
        last_d  = last_q;
        word2_d = word2_q;
        if (state_q == ST_HOLD2 && advance) begin
            vld_d   = 1'b1;
            instr_d = word2_q;
            last_d  = 1'b1;
        end
`endif
        if (accept) begin
            if (legal) begin
                vld_d   = 1'b1;
                instr_d = word1;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
                last_d  = ~two_words;
                word2_d = word2;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Output and word-2 registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q   <= 1'b0;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
            last_q  <= 1'b0;
            word2_q <= 32'd0;
`endif
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef OSIRIS_PSEUDO_EXPAND_EN
            last_q  <= last_d;
            word2_q <= word2_d;
`endif
        end
    end

    assign o_cmd_ready   = cmd_ready;
    assign o_instr_valid = vld_q;
    assign o_instr       = instr_q;
    assign o_cmd_err     = err_q;

endmodule
